// File: rtl/ccip_c0_rd_arbiter_pkg.sv
// Shared types and constants for the CCI-P c0 read-request arbiter.
package ccip_arb_pkg;

    localparam int CCIP_ADDR_W  = 42;
    localparam int CCIP_MDATA_W = 16;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        DRAINED = 2'd2
    } t_arb_state;

    // Lowest mdata bit occupied by the requester tag (the tag sits in the top bits).
    function automatic int tag_lsb(input int tag_w);
        return CCIP_MDATA_W - tag_w;
    endfunction

endpackage

// File: rtl/ccip_c0_rd_arbiter_if.sv
// Bundle of the engine-side, CCI-P c0 and drain/debug signals of the read arbiter.
interface ccip_c0_rd_arbiter_if
    import ccip_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_OUTST = 64,
    parameter int TAG_W     = $clog2(NUM_REQ),
    parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) ();

    logic [NUM_REQ-1:0]                       req_valid;
    logic [NUM_REQ*CCIP_ADDR_W-1:0]           req_addr;
    logic [NUM_REQ*(CCIP_MDATA_W-TAG_W)-1:0]  req_mdata;
    logic [NUM_REQ-1:0]                       req_grant;

    logic                                     c0TxAlmFull;
    logic                                     c0Tx_valid;
    logic [CCIP_ADDR_W-1:0]                   c0Tx_addr;
    logic [CCIP_MDATA_W-1:0]                  c0Tx_mdata;

    logic                                     c0Rx_rdValid;
    logic [CCIP_MDATA_W-1:0]                  c0Rx_mdata;
    logic [NUM_REQ-1:0]                       rsp_route;

    logic                                     drain_req;
    logic                                     drain_done;
    logic [NUM_REQ*CNT_W-1:0]                 outst_cnt;

    // Arbiter side
    modport slave (
        input  req_valid, req_addr, req_mdata, c0TxAlmFull,
               c0Rx_rdValid, c0Rx_mdata, drain_req,
        output req_grant, c0Tx_valid, c0Tx_addr, c0Tx_mdata,
               rsp_route, drain_done, outst_cnt
    );

    // Engines / platform side
    modport master (
        output req_valid, req_addr, req_mdata, c0TxAlmFull,
               c0Rx_rdValid, c0Rx_mdata, drain_req,
        input  req_grant, c0Tx_valid, c0Tx_addr, c0Tx_mdata,
               rsp_route, drain_done, outst_cnt
    );

endinterface

// File: rtl/ccip_c0_rd_arbiter_rr_arbiter.sv
// Generic round-robin arbiter; the search starts at the pointer and the pointer
// moves just past the winner whenever a grant is taken.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          found;
    int            idx;

    // Pick the first requester at or after the pointer, wrapping around
    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                if (advance) begin
                    ptr_d = PW'((idx + 1) % N);
                end
            end
        end
    end

    // Pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ccip_c0_rd_arbiter.sv
// Shares the CCI-P c0 read-request channel among NUM_REQ DMA read engines,
// tags requests with the engine index and routes responses back by that tag.
module ccip_c0_rd_arbiter
    import ccip_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_OUTST = 64,
    parameter int TAG_W     = $clog2(NUM_REQ),
    parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
    input logic                 pClk,
    input logic                 pck_cp2af_softReset_n,
    ccip_c0_rd_arbiter_if.slave bus
);

    localparam int TAG_LSB = tag_lsb(TAG_W);
    localparam int PMD_W   = CCIP_MDATA_W - TAG_W;

    t_arb_state              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q [NUM_REQ];
    logic [CNT_W-1:0]        cnt_d [NUM_REQ];
    logic [NUM_REQ-1:0]      elig;
    logic [NUM_REQ-1:0]      grant;
    logic [NUM_REQ-1:0]      rsp_hit;
    logic [NUM_REQ-1:0]      rsp_route_q;
    logic                    c0tx_valid_q, c0tx_valid_d;
    logic [CCIP_ADDR_W-1:0]  c0tx_addr_q, c0tx_addr_d;
    logic [CCIP_MDATA_W-1:0] c0tx_mdata_q, c0tx_mdata_d;
    logic [TAG_W-1:0]        rx_tag;
    logic                    rx_tag_ok;
    logic                    run_ok;
    logic                    all_idle;

    assign rx_tag    = bus.c0Rx_mdata[CCIP_MDATA_W-1:TAG_LSB];
    assign rx_tag_ok = (32'(rx_tag) < NUM_REQ);
    // Reset is folded in so no grant can appear while the block is held in reset.
    assign run_ok    = pck_cp2af_softReset_n && !bus.c0TxAlmFull &&
                       (state_q == RUN) && !bus.drain_req;

    // Per-requester eligibility and response decode
    always_comb begin
        elig    = '0;
        rsp_hit = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i]    = run_ok && bus.req_valid[i] && (cnt_q[i] < CNT_W'(MAX_OUTST));
            rsp_hit[i] = bus.c0Rx_rdValid && rx_tag_ok && (rx_tag == TAG_W'(i));
        end
    end

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk     (pClk),
        .rst_n   (pck_cp2af_softReset_n),
        .req     (elig),
        .advance (run_ok),
        .grant   (grant)
    );

    // Capture the granted request; address/mdata hold when nothing is granted
    always_comb begin
        c0tx_valid_d = |grant;
        c0tx_addr_d  = c0tx_addr_q;
        c0tx_mdata_d = c0tx_mdata_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                c0tx_addr_d  = bus.req_addr[i*CCIP_ADDR_W +: CCIP_ADDR_W];
                c0tx_mdata_d = {TAG_W'(i), bus.req_mdata[i*PMD_W +: PMD_W]};
            end
        end
    end

    // Outstanding counters: +1 on grant, -1 on response, both cancel, floor at 0
    always_comb begin
        all_idle = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (grant[i] && !rsp_hit[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (!grant[i] && rsp_hit[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
            if (cnt_d[i] != '0) begin
                all_idle = 1'b0;
            end
        end
    end

    // Drain sequencing; DRAINED is entered the cycle after the last response lands
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (bus.drain_req) state_d = DRAIN;
            end
            DRAIN: begin
                if (!bus.drain_req)                  state_d = RUN;
                else if (all_idle && !c0tx_valid_q)  state_d = DRAINED;
            end
            DRAINED: begin
                if (!bus.drain_req) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // State, Tx, counter and routing registers
    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            state_q      <= RUN;
            c0tx_valid_q <= 1'b0;
            c0tx_addr_q  <= '0;
            c0tx_mdata_q <= '0;
            rsp_route_q  <= '0;
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            c0tx_valid_q <= c0tx_valid_d;
            c0tx_addr_q  <= c0tx_addr_d;
            c0tx_mdata_q <= c0tx_mdata_d;
            rsp_route_q  <= rsp_hit;
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Flatten counters for the debug/CSR port
    always_comb begin
        bus.outst_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.outst_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    assign bus.req_grant  = grant;
    assign bus.c0Tx_valid = c0tx_valid_q;
    assign bus.c0Tx_addr  = c0tx_addr_q;
    assign bus.c0Tx_mdata = c0tx_mdata_q;
    assign bus.rsp_route  = rsp_route_q;
    assign bus.drain_done = (state_q == DRAINED);

    // A response must never arrive for a requester with nothing outstanding
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_underflow_chk
        assert property (@(posedge pClk) disable iff (!pck_cp2af_softReset_n)
            !(rsp_hit[g] && !grant[g] && (cnt_q[g] == '0)));
    end

    // A response tag must name an existing requester
    assert property (@(posedge pClk) disable iff (!pck_cp2af_softReset_n)
        !(bus.c0Rx_rdValid && !rx_tag_ok));

endmodule

// File: tb/tb_ccip_c0_rd_arbiter.sv
// Scoreboard bench for ccip_c0_rd_arbiter with 4 requesters and 64 credits each.
module tb_ccip_c0_rd_arbiter;

   localparam int NREQ = 4;
   localparam int MAXO = 64;
   localparam int CW   = 7;

   typedef struct packed {
      logic [41:0] addr;
      logic [15:0] mdata;
   } txExp_t;

   logic clock;
   logic resetN;

   ccip_c0_rd_arbiter_if #(.NUM_REQ(NREQ), .MAX_OUTST(MAXO)) bus ();

   ccip_c0_rd_arbiter #(.NUM_REQ(NREQ), .MAX_OUTST(MAXO)) dut (
      .pClk                  (clock),
      .pck_cp2af_softReset_n (resetN),
      .bus                   (bus)
   );

   int totalChecks = 0;
   int badChecks   = 0;

   int mCnt [NREQ];
   int mPtr;
   int mState;
   txExp_t txQ[$];
   logic [3:0] routeQ[$];
   logic [41:0] curAddr [NREQ];
   logic [13:0] curMd [NREQ];

   // Free-running clock, period 10
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Watchdog so the run can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point for every check in the bench
   task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
      totalChecks++;
      if (act !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic bit anyOutstanding();
      for (int i = 0; i < NREQ; i++) if (mCnt[i] > 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [1:0] pickTag();
      int off = $urandom_range(0, NREQ - 1);
      for (int k = 0; k < NREQ; k++) if (mCnt[(off + k) % NREQ] > 0) return 2'((off + k) % NREQ);
      return 2'd0;
   endfunction

   function automatic logic [27:0] expCntVec();
      logic [27:0] v = '0;
      for (int i = 0; i < NREQ; i++) v[i*CW +: CW] = CW'(mCnt[i]);
      return v;
   endfunction

   task automatic resetModel();
      for (int i = 0; i < NREQ; i++) mCnt[i] = 0;
      mPtr   = 0;
      mState = 0;
      txQ.delete();
      routeQ.delete();
   endtask

   // Drive one cycle of inputs, check the DUT at the falling edge, advance the model
   task automatic applyStimulus(input logic [3:0] valid, input logic alm, input logic rspV,
                                input logic [1:0] rspTag, input logic drain);
      logic [3:0] expGrant;
      logic [3:0] expRoute;
      int gi;
      bit txNow;
      bit idle;
      int newCnt [NREQ];
      txExp_t e;

      for (int i = 0; i < NREQ; i++) begin
         curAddr[i] = {$urandom(), 10'($urandom())};
         curMd[i]   = 14'($urandom());
         bus.req_addr[i*42 +: 42]  = curAddr[i];
         bus.req_mdata[i*14 +: 14] = curMd[i];
      end
      bus.req_valid    = valid;
      bus.c0TxAlmFull  = alm;
      bus.c0Rx_rdValid = rspV;
      bus.c0Rx_mdata   = {rspTag, 14'($urandom())};
      bus.drain_req    = drain;
      #4;

      expGrant = '0;
      gi = -1;
      if (mState == 0 && !drain && !alm) begin
         for (int k = 0; k < NREQ; k++) begin
            int idx = (mPtr + k) % NREQ;
            if (gi < 0 && valid[idx] && mCnt[idx] < MAXO) begin
               gi = idx;
               expGrant[idx] = 1'b1;
            end
         end
      end
      checkOutput("grant", 64'(bus.req_grant), 64'(expGrant));

      txNow = (txQ.size() > 0);
      checkOutput("tx_valid", 64'(bus.c0Tx_valid), 64'(txNow));
      if (txNow) begin
         e = txQ.pop_front();
         checkOutput("tx_addr", 64'(bus.c0Tx_addr), 64'(e.addr));
         checkOutput("tx_mdata", 64'(bus.c0Tx_mdata), 64'(e.mdata));
      end
      if (gi >= 0) begin
         e.addr  = curAddr[gi];
         e.mdata = {2'(gi), curMd[gi]};
         txQ.push_back(e);
      end

      expRoute = (routeQ.size() > 0) ? routeQ.pop_front() : 4'b0000;
      checkOutput("rsp_route", 64'(bus.rsp_route), 64'(expRoute));
      routeQ.push_back(rspV ? (4'b0001 << rspTag) : 4'b0000);

      checkOutput("drain_done", 64'(bus.drain_done), 64'(mState == 2));
      checkOutput("outst_cnt", 64'(bus.outst_cnt), 64'(expCntVec()));

      idle = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         newCnt[i] = mCnt[i] + (expGrant[i] ? 1 : 0) - ((rspV && rspTag == 2'(i)) ? 1 : 0);
         if (newCnt[i] != 0) idle = 1'b0;
      end
      case (mState)
         0: if (drain) mState = 1;
         1: if (!drain) mState = 0; else if (idle && !txNow) mState = 2;
         default: if (!drain) mState = 0;
      endcase
      for (int i = 0; i < NREQ; i++) mCnt[i] = newCnt[i];
      if (gi >= 0) mPtr = (gi + 1) % NREQ;

      @(posedge clock);
      #1;
   endtask

   // Return every outstanding read so the next scenario starts from empty counters
   task automatic clearOutstanding();
      for (int n = 0; n < 600 && anyOutstanding(); n++) applyStimulus(4'h0, 1'b0, 1'b1, pickTag(), 1'b0);
      checkOutput("cleared", 64'(bus.outst_cnt), 64'd0);
   endtask

   initial begin
      resetN = 1'b0;
      bus.req_valid    = '0;
      bus.req_addr     = '0;
      bus.req_mdata    = '0;
      bus.c0TxAlmFull  = 1'b0;
      bus.c0Rx_rdValid = 1'b0;
      bus.c0Rx_mdata   = '0;
      bus.drain_req    = 1'b0;
      resetModel();
      repeat (2) @(posedge clock);
      #1;
      checkOutput("rst_tx_valid", 64'(bus.c0Tx_valid), 64'd0);
      checkOutput("rst_tx_addr", 64'(bus.c0Tx_addr), 64'd0);
      checkOutput("rst_route", 64'(bus.rsp_route), 64'd0);
      checkOutput("rst_done", 64'(bus.drain_done), 64'd0);
      checkOutput("rst_cnt", 64'(bus.outst_cnt), 64'd0);
      resetN = 1'b1;

      // Round-robin over all four requesters
      for (int c = 0; c < 9; c++) applyStimulus(4'hF, 1'b0, 1'b0, 2'd0, 1'b0);
      clearOutstanding();

      // Requester 2 alone until credits run out, then one response frees a credit
      for (int c = 0; c < 68; c++) applyStimulus(4'b0100, 1'b0, 1'b0, 2'd0, 1'b0);
      checkOutput("cnt2_sat", 64'(bus.outst_cnt[2*CW +: CW]), 64'd64);
      applyStimulus(4'b0100, 1'b0, 1'b1, 2'd2, 1'b0);
      checkOutput("cnt2_after_rsp", 64'(bus.outst_cnt[2*CW +: CW]), 64'd63);
      applyStimulus(4'b0100, 1'b0, 1'b0, 2'd0, 1'b0);
      checkOutput("cnt2_regrant", 64'(bus.outst_cnt[2*CW +: CW]), 64'd64);
      clearOutstanding();

      // Almost-full blocks all grants; pointer is held across it
      applyStimulus(4'hF, 1'b0, 1'b0, 2'd0, 1'b0);
      for (int c = 0; c < 10; c++) applyStimulus(4'hF, 1'b1, 1'b0, 2'd0, 1'b0);
      for (int c = 0; c < 4; c++) applyStimulus(4'hF, 1'b0, 1'b0, 2'd0, 1'b0);
      clearOutstanding();

      // Grant and response for requester 1 in the same cycle at cnt=5
      for (int c = 0; c < 5; c++) applyStimulus(4'b0010, 1'b0, 1'b0, 2'd0, 1'b0);
      applyStimulus(4'b0010, 1'b0, 1'b1, 2'd1, 1'b0);
      checkOutput("cnt1_same_cycle", 64'(bus.outst_cnt[1*CW +: CW]), 64'd5);
      checkOutput("route1", 64'(bus.rsp_route), 64'b0010);
      clearOutstanding();

      // Drain with three reads outstanding
      for (int c = 0; c < 3; c++) applyStimulus(4'hF, 1'b0, 1'b0, 2'd0, 1'b0);
      for (int c = 0; c < 3; c++) applyStimulus(4'hF, 1'b0, 1'b0, 2'd0, 1'b1);
      for (int n = 0; n < 20 && anyOutstanding(); n++) applyStimulus(4'hF, 1'b0, 1'b1, pickTag(), 1'b1);
      checkOutput("drain_done_set", 64'(bus.drain_done), 64'd1);
      applyStimulus(4'hF, 1'b0, 1'b0, 2'd0, 1'b1);
      applyStimulus(4'hF, 1'b0, 1'b0, 2'd0, 1'b0);
      for (int c = 0; c < 3; c++) applyStimulus(4'hF, 1'b0, 1'b0, 2'd0, 1'b0);
      clearOutstanding();

      // Mixed random traffic
      for (int c = 0; c < 200; c++) begin
         logic rv;
         rv = anyOutstanding() && ($urandom_range(0, 1) == 1);
         applyStimulus(4'($urandom()), ($urandom_range(0, 7) == 0), rv, rv ? pickTag() : 2'd0, 1'b0);
      end

      // Reset in the middle of a burst
      for (int c = 0; c < 6; c++) applyStimulus(4'hF, 1'b0, 1'b0, 2'd0, 1'b0);
      #2;
      resetN = 1'b0;
      #1;
      checkOutput("mid_rst_grant", 64'(bus.req_grant), 64'd0);
      checkOutput("mid_rst_tx_valid", 64'(bus.c0Tx_valid), 64'd0);
      checkOutput("mid_rst_tx_mdata", 64'(bus.c0Tx_mdata), 64'd0);
      checkOutput("mid_rst_route", 64'(bus.rsp_route), 64'd0);
      checkOutput("mid_rst_cnt", 64'(bus.outst_cnt), 64'd0);
      resetModel();
      @(posedge clock);
      #1;
      bus.req_valid = '0;
      resetN = 1'b1;
      applyStimulus(4'hF, 1'b0, 1'b0, 2'd0, 1'b0);
      checkOutput("post_rst_first_tag", 64'(bus.c0Tx_mdata[15:14]), 64'd0);
      applyStimulus(4'hF, 1'b0, 1'b0, 2'd0, 1'b0);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule

// File: doc/ccip_c0_rd_arbiter.md
Name: ccip_c0_rd_arbiter

Overview:
- Shares the single CCI-P c0 Tx read-request channel of the AFU among NUM_REQ DMA read engines.
- Uses round-robin arbitration with per-requester outstanding-read credits and honours c0TxAlmFull.
- Tags each request's mdata with the requester index and routes c0 Rx read responses back by that tag.
- Provides a drain/quiesce sequence for clean engine reset.
- Sits between the DMA engines and the registered CCI-P Tx/Rx ports in the pClk domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TAG_W, $clog2(NUM_REQ), requester tag width placed in mdata[15:16-TAG_W].
- MAX_OUTST, 64, maximum outstanding single-line reads per requester.
- CNT_W, $clog2(MAX_OUTST+1), outstanding-counter width.

Ports:
- pClk  in  1  CCI-P primary clock (400 MHz).
- pck_cp2af_softReset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester read request pending.
- req_addr  in  NUM_REQ*42  per-requester cache-line address.
- req_mdata  in  NUM_REQ*(16-TAG_W)  per-requester private mdata.
- req_grant  out  NUM_REQ  one-hot, request consumed this cycle.
- c0TxAlmFull  in  1  CCI-P c0 Tx almost-full.
- c0Tx_valid  out  1  registered read request valid.
- c0Tx_addr  out  42  registered address.
- c0Tx_mdata  out  16  {tag, req_mdata}.
- c0Rx_rdValid  in  1  read response valid (resp type decoded upstream).
- c0Rx_mdata  in  16  response mdata.
- rsp_route  out  NUM_REQ  one-hot, response belongs to requester i.
- drain_req  in  1  level, request quiesce.
- drain_done  out  1  all outstanding reads returned, no grants.
- outst_cnt  out  NUM_REQ*CNT_W  per-requester outstanding count (debug/CSR).

Behaviour:
- Reset values: all outputs 0, rr pointer 0, counters 0, FSM RUN.
- Eligibility of requester i: req_valid[i] & (cnt[i] < MAX_OUTST) & !c0TxAlmFull & state==RUN.
- Grant and arbitration:
  - req_grant is combinational from current-cycle eligibility; at most one bit set.
  - Round-robin search starts at the rr pointer. After a grant to i, the pointer becomes (i+1) mod NUM_REQ. With no grant, the pointer holds.
  - A granted requester must drop or advance its request the next cycle (valid/grant handshake, no ready).
- Tx registering: the cycle after a grant, c0Tx_valid=1, c0Tx_addr=req_addr[i], c0Tx_mdata={i[TAG_W-1:0], req_mdata[i]}. Otherwise c0Tx_valid=0 and addr/mdata hold. Grant-to-Tx latency is 1 cycle.
- c0TxAlmFull is sampled combinationally. The at-most-one in-flight registered request issued after almFull rises is within the CCI-P 8-request slack.
- Requests are single-line only (cl_len 1); one response per request, cl_num ignored.
- Counters:
  - cnt[i] increments on req_grant[i].
  - cnt[i] decrements on c0Rx_rdValid with c0Rx_mdata[15:16-TAG_W]==i.
  - Simultaneous inc and dec on the same i leaves cnt unchanged.
  - Decrement at 0 is a protocol error: cnt saturates at 0 and an assertion fires in simulation.
  - Increment beyond MAX_OUTST cannot occur by construction.
- Response routing: rsp_route registered, 1-cycle latency. It is one-hot of the tag when c0Rx_rdValid, else 0. A tag >= NUM_REQ yields rsp_route=0 plus a simulation assertion.
- FSM:
  - RUN: normal operation. drain_req=1 -> DRAIN. Grants stop in the same cycle drain_req is seen.
  - DRAIN: no grants. All cnt==0 and no c0Tx_valid in flight -> DRAINED.
  - DRAINED: drain_done=1, no grants. drain_req=0 -> RUN.
  - drain_req dropping during DRAIN -> RUN; drain_done stays 0.
- Reset mid-operation: everything clears asynchronously. Responses to pre-reset requests must not arrive after reset release (platform guarantee of soft reset).

Decomposition:
- Package ccip_arb_pkg: t_arb_state enum (RUN, DRAIN, DRAINED), CCIP_ADDR_W=42, CCIP_MDATA_W=16, and a function for the tag slice position.
- Sub-module rr_arbiter (parameter N): inputs req[N] and advance; outputs one-hot grant[N]; owns the rr pointer. Reused by the c1 write-side arbiter.

Test Plan:
- All 4 valid continuously, almFull=0 -> grants cycle 0,1,2,3,0…; c0Tx_mdata[15:14] tracks each grant one cycle later.
- Requester 2 alone, 64 grants, no responses -> grant stops at cnt=64; one response with mdata[15:14]=2 -> cnt=63, next cycle re-granted.
- almFull=1 for 10 cycles with all requesting -> zero grants; c0Tx_valid=0 from cycle 2 of almFull; on release, arbitration resumes at the held pointer.
- Same-cycle grant and response for requester 1 at cnt=5 -> cnt stays 5; rsp_route=4'b0010 one cycle later.
- drain_req with 3 outstanding -> no grants; drain_done=1 one cycle after the last response; drain_req=0 -> grants resume.
- Assert reset mid-burst with cnt≠0 -> all outputs and counters 0 immediately; first grant after release goes to requester 0.
